// File: rtl/counter_pkg.sv
// Shared definitions for the parameterised counter: mode encodings and direction values.
package counter_pkg;

  typedef enum logic [1:0] {
    UP     = 2'd0,
    DOWN   = 2'd1,
    BOUNCE = 2'd2,
    HOLD   = 2'd3
  } mode_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/tick_divider.sv
// Enable-gated prescaler: emits a one-cycle tick on every DIV-th enabled cycle.
module tick_divider #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  if (DIV < 1) begin : g_bad_div
    $error("tick_divider: DIV must be >= 1 (got %0d)", DIV);
  end

  logic [CW-1:0] cnt_p0;

  // Tick is combinational so the counter steps on the same edge the divider wraps.
  assign tick = en && (cnt_p0 == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_p0 <= '0;
    end else if (clr) begin
      cnt_p0 <= '0;
    end else if (en) begin
      cnt_p0 <= (cnt_p0 == LAST) ? '0 : cnt_p0 + ONE;
    end
  end

endmodule

// File: rtl/param_counter.sv
// Modulo counter with up/down/bounce/hold modes, prescaled stepping, clear, clamped load
// and a registered terminal-count pulse.
module param_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 2,
  parameter int MODULUS  = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             dir
);

  if (MODULUS < 2 || $clog2(MODULUS) > WIDTH) begin : g_bad_mod
    $error("param_counter: MODULUS %0d outside 2..2**WIDTH (WIDTH=%0d)", MODULUS, WIDTH);
  end
  if (PRESCALE < 1) begin : g_bad_pre
    $error("param_counter: PRESCALE must be >= 1 (got %0d)", PRESCALE);
  end

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Out-of-range load values saturate to the top state so q never leaves 0..MODULUS-1.
  function automatic logic [WIDTH-1:0] sat_load(input logic [WIDTH-1:0] v);
    return (v > MAX) ? MAX : v;
  endfunction

  function automatic logic [WIDTH-1:0] inc_wrap(input logic [WIDTH-1:0] v);
    return (v == MAX) ? '0 : v + ONE;
  endfunction

  function automatic logic [WIDTH-1:0] dec_wrap(input logic [WIDTH-1:0] v);
    return (v == '0) ? MAX : v - ONE;
  endfunction

  logic             step_p0;
  logic             div_clr;
  logic [WIDTH-1:0] q_p0,   q_nx;
  logic             dir_p0, dir_nx;
  logic             tc_p0,  tc_nx;
  mode_e            mode_s;

  assign mode_s  = mode_e'(mode);
  assign div_clr = clr | load;

  tick_divider #(
    .DIV (PRESCALE)
  ) u_div (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (div_clr),
    .tick (step_p0)
  );

  // Stage p0 -> p1: next-state selection with clr > load > step > hold priority.
  always_comb begin
    q_nx   = q_p0;
    dir_nx = dir_p0;
    tc_nx  = 1'b0;
    if (clr) begin
      q_nx   = '0;
      dir_nx = DIR_UP;
    end else if (load) begin
      q_nx = sat_load(load_val);
    end else if (step_p0) begin
      case (mode_s)
        UP: begin
          dir_nx = DIR_UP;
          q_nx   = inc_wrap(q_p0);
          tc_nx  = (q_p0 == MAX);
        end
        DOWN: begin
          dir_nx = DIR_DOWN;
          q_nx   = dec_wrap(q_p0);
          tc_nx  = (q_p0 == '0);
        end
        BOUNCE: begin
          if (dir_p0 == DIR_UP && q_p0 == MAX) begin
            q_nx   = MAX - ONE;
            dir_nx = DIR_DOWN;
            tc_nx  = 1'b1;
          end else if (dir_p0 == DIR_DOWN && q_p0 == '0) begin
            q_nx   = ONE;
            dir_nx = DIR_UP;
            tc_nx  = 1'b1;
          end else if (dir_p0 == DIR_DOWN) begin
            q_nx = q_p0 - ONE;
          end else begin
            q_nx = q_p0 + ONE;
          end
        end
        HOLD: begin
          q_nx = q_p0;
        end
        default: begin
          q_nx = q_p0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_p0   <= '0;
      dir_p0 <= DIR_UP;
      tc_p0  <= 1'b0;
    end else begin
      q_p0   <= q_nx;
      dir_p0 <= dir_nx;
      tc_p0  <= tc_nx;
    end
  end

  assign q   = q_p0;
  assign dir = dir_p0;
  assign tc  = tc_p0;

endmodule
